signed_shift_divide: RTL and testbench
======================================

# signed_shift_divide

Sequential 4-bit signed divider using restoring shift-subtract. It is the inverse companion of the calculator's shift-add multiplier and sits beside it in the ALU datapath. It accepts a dividend and divisor on a one-cycle `start` pulse and returns a truncated quotient and remainder after a fixed latency. A one-cycle `divide_done` strobe marks completion, and the block flags divide-by-zero and overflow.

## Interface
Parameters: none (widths fixed at 4 bits).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request pulse. Sampled only in IDLE.
- `a` in 4: signed dividend, two's complement. Captured on accepted `start`.
- `b` in 4: signed divisor, two's complement. Captured on accepted `start`.
- `quotient` out 4: signed quotient, registered.
- `remainder` out 4: signed remainder, registered. See Configuration.
- `div_by_zero` out 1: set when `b == 0`, registered.
- `overflow` out 1: set for -8 / -1, registered.
- `busy` out 1: high in every state except IDLE.
- `divide_done` out 1: high exactly one cycle per operation.

## Operation
Arithmetic:
- Truncation toward zero.
- Remainder takes the sign of the dividend.
- Invariant when no flag is set: a = quotient*b + remainder.

State machine (registered state; all transitions on the `clk` edge):
- IDLE: `start` → LOAD. Latch `a`/`b` into internal registers; inputs are don't-care afterwards.
- LOAD:
  - Compute |a| and |b| as 4-bit unsigned magnitudes (|-8| = 8 fits unsigned).
  - Record result sign = a[3]^b[3] and remainder sign = a[3].
  - Clear the 5-bit partial remainder. Clear iteration count.
  - Go to ITER.
- ITER (exactly 4 cycles, count 0..3):
  - r ← {r[3:0], q[3]}; q ← q<<1.
  - If r ≥ |b|: r ← r − |b| and q[0] ← 1.
  - After count 3 → FIX.
- FIX: write the output registers.
  - Default: `quotient` = sign ? −q : q; `remainder` = a[3] ? −r : r.
  - If |b| == 0: `quotient` = 0, `remainder` = a, `div_by_zero` = 1, `overflow` = 0.
  - Else if a == −8 and b == −1: `quotient` = 4'b0111 (saturated), `remainder` = 0, `overflow` = 1.
  - Go to DONE.
- DONE: `divide_done` = 1. Unconditionally → IDLE.

Boundary rules:
- `start` outside IDLE, including DONE, is ignored; it is not queued.
- Divide-by-zero and overflow do not shorten latency. Every operation takes the same cycle count.
- Outputs and flags hold their values from FIX until the next FIX. `start` does not clear them.
- `rst` asserted in any state:
  - Immediately forces IDLE.
  - All outputs go to 0: `quotient`, `remainder`, flags, `busy`, `divide_done`.
  - Internal registers are cleared.
  - No `divide_done` is produced for the aborted operation.

## Timing
- Edge E0 samples `start` in IDLE. E1 LOAD, E2–E5 ITER, E6 FIX.
- `divide_done` is high during the cycle after E6, i.e. 7 cycles after the `start` edge, for one cycle.
- Results are valid from the same cycle as `divide_done` and stable thereafter.
- `busy` rises in the cycle after E0 and falls after E7.
- Earliest back-to-back `start` is sampled at E8, so throughput is one operation per 8 cycles.
- `divide_done` is decoded from the registered state (state == DONE). There is no combinational input→output path.
- Reset value of every output: 0.

## Configuration
Macro `DIVIDE_REMAINDER_EN`:
- Defined: `remainder` carries the signed remainder as specified.
- Undefined:
  - `remainder` is tied to 4'b0000.
  - The sign-correction logic for the remainder is removed. The divide-by-zero remainder copy is removed.
  - The partial remainder is still used internally.
  - Quotient, flags and timing are identical in both builds.

## Structure
Shared package/header `divide_defs`:
- State encodings IDLE/LOAD/ITER/FIX/DONE (3-bit).
- Width constant DIV_W = 4.
- Iteration count constant = DIV_W.

One sub-module, `divide_complement_to_2`:
- 4-bit two's-complement negation with an enable.
- Used for operand magnitudes in LOAD and for sign correction in FIX.
- Implemented as a single instance per use, or time-shared via a mux.

## Test plan
- 7 / 2, `start` at E0 → `divide_done` at E0+7, `quotient` = 4'b0011, `remainder` = 4'b0001, flags 0.
- −7 / 2 (4'b1001 / 4'b0010) → `quotient` = 4'b1101 (−3), `remainder` = 4'b1111 (−1).
- 6 / −3 → `quotient` = 4'b1110 (−2), `remainder` = 0. Then 3 / 5 → `quotient` = 0, `remainder` = 3.
- −8 / −1 → `quotient` = 4'b0111, `remainder` = 0, `overflow` = 1. Then 5 / 0 → `quotient` = 0, `remainder` = 5, `div_by_zero` = 1, `overflow` = 0, latency still 7.
- `start` pulsed again at E3 during ITER → ignored: single `divide_done` at E0+7 with the first operands' result; `busy` stays high throughout.
- `rst` asserted mid-ITER → all outputs 0 immediately, no `divide_done`. Next `start` with 4 / 2 → `quotient` = 2 after 7 cycles.

Source files
------------

// File: rtl/signed_shift_divide_pkg.sv
// Shared definitions for the 4-bit signed restoring divider: width, iteration count, FSM encodings.
package divide_defs;
  localparam int DIV_W     = 4;
  localparam int DIV_ITERS = DIV_W;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
endpackage

// File: rtl/signed_shift_divide_complement_to_2.sv
// Two's-complement negation with enable; passes the value through unchanged when disabled.
module divide_complement_to_2
  import divide_defs::*;
(
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_val,
  output logic [DIV_W-1:0] o_val
);

  logic [DIV_W-1:0] w_neg;

  assign w_neg = ~i_val + {{(DIV_W-1){1'b0}}, 1'b1};
  assign o_val = i_en ? w_neg : i_val;

endmodule

// File: rtl/signed_shift_divide.sv
// Sequential 4-bit signed restoring divider, fixed 8-cycle operation with done strobe and flags.
// Build option DIVIDE_REMAINDER_EN: when defined, the signed remainder is driven; otherwise it reads 0.
module signed_shift_divide
  import divide_defs::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [DIV_W-1:0] a,
  input  logic signed [DIV_W-1:0] b,
  output logic signed [DIV_W-1:0] quotient,
  output logic signed [DIV_W-1:0] remainder,
  output logic                    div_by_zero,
  output logic                    overflow,
  output logic                    busy,
  output logic                    divide_done
);

  logic [2:0]              r_state;
  logic [1:0]              r_cnt;
  logic signed [DIV_W-1:0] r_a;
  logic signed [DIV_W-1:0] r_b;
  logic [DIV_W-1:0]        r_q;
  logic [DIV_W-1:0]        r_rem;
  logic [DIV_W-1:0]        r_mag_b;
  logic                    r_qsign;
  logic signed [DIV_W-1:0] r_quotient;
  logic                    r_div_by_zero;
  logic                    r_overflow;

  logic [DIV_W-1:0]        w_mag_a;
  logic [DIV_W-1:0]        w_mag_b;
  logic [DIV_W-1:0]        w_q_fix;
  logic [DIV_W:0]          w_shift;
  logic [DIV_W:0]          w_diff;
  logic                    w_ge;
  logic                    w_ovf_case;

  divide_complement_to_2 u_mag_a (.i_en(r_a[DIV_W-1]), .i_val(r_a), .o_val(w_mag_a));
  divide_complement_to_2 u_mag_b (.i_en(r_b[DIV_W-1]), .i_val(r_b), .o_val(w_mag_b));
  divide_complement_to_2 u_fix_q (.i_en(r_qsign),      .i_val(r_q), .o_val(w_q_fix));

  // Trial remainder is 5 bits wide; after restoring it is always below |b| <= 8, so 4 bits are stored.
  assign w_shift    = {r_rem, r_q[DIV_W-1]};
  assign w_ge       = (w_shift >= {1'b0, r_mag_b});
  assign w_diff     = w_shift - {1'b0, r_mag_b};
  assign w_ovf_case = (r_a == 4'b1000) && (r_b == 4'b1111);

`ifdef DIVIDE_REMAINDER_EN
  logic                    r_rsign;
  logic signed [DIV_W-1:0] r_remainder;
  logic [DIV_W-1:0]        w_rem_fix;

  divide_complement_to_2 u_fix_r (.i_en(r_rsign), .i_val(r_rem), .o_val(w_rem_fix));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsign     <= 1'b0;
      r_remainder <= '0;
    end else begin
      if (r_state == ST_LOAD)
        r_rsign <= r_a[DIV_W-1];
      if (r_state == ST_FIX) begin
        if (r_mag_b == '0)
          r_remainder <= r_a;
        else if (w_ovf_case)
          r_remainder <= '0;
        else
          r_remainder <= w_rem_fix;
      end
    end
  end

  assign remainder = r_remainder;
`else
  assign remainder = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_q           <= '0;
      r_rem         <= '0;
      r_mag_b       <= '0;
      r_qsign       <= 1'b0;
      r_quotient    <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_q     <= w_mag_a;
          r_mag_b <= w_mag_b;
          r_qsign <= r_a[DIV_W-1] ^ r_b[DIV_W-1];
          r_rem   <= '0;
          r_cnt   <= '0;
          r_state <= ST_ITER;
        end
        ST_ITER: begin
          r_rem <= w_ge ? w_diff[DIV_W-1:0] : w_shift[DIV_W-1:0];
          r_q   <= {r_q[DIV_W-2:0], w_ge};
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'(DIV_ITERS - 1))
            r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (r_mag_b == '0) begin
            r_quotient    <= '0;
            r_div_by_zero <= 1'b1;
            r_overflow    <= 1'b0;
          end else if (w_ovf_case) begin
            r_quotient    <= 4'b0111;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b1;
          end else begin
            r_quotient    <= w_q_fix;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;
  assign busy        = (r_state != ST_IDLE);
  assign divide_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_signed_shift_divide.sv
// Directed bench for signed_shift_divide: latency, results, flags, ignored start, mid-operation reset.
module tb_signed_shift_divide;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       overflow;
  logic       busy;
  logic       divide_done;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef DIVIDE_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  signed_shift_divide dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .busy        (busy),
    .divide_done (divide_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] rem_exp(input logic [3:0] r);
    return REM_EN ? r : 4'd0;
  endfunction

  // One operation: start sampled at E0, optional second start pulse sampled at edge E<inj>.
  task automatic run_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                        input logic [3:0] eq, input logic [3:0] er,
                        input logic edz, input logic eov,
                        input logic [3:0] prev_q, input int inj);
    int   cyc;
    logic busy_ok;
    @(posedge clk); #1;
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ia; b = ~ib;
    cyc = 1;
    busy_ok = 1'b1;
    chk({tag, " hold_prev_q"}, 32'(quotient), 32'(prev_q));
    while (!divide_done && cyc < 20) begin
      if (!busy) busy_ok = 1'b0;
      if (cyc == inj) begin
        start = 1'b1; a = 4'd1; b = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, " latency"},   32'(cyc), 32'd7);
    chk({tag, " busy_run"},  32'(busy_ok), 32'd1);
    chk({tag, " busy_done"}, 32'(busy), 32'd1);
    chk({tag, " quotient"},  32'(quotient), 32'(eq));
    chk({tag, " remainder"}, 32'(remainder), 32'(rem_exp(er)));
    chk({tag, " div0"},      32'(div_by_zero), 32'(edz));
    chk({tag, " ovf"},       32'(overflow), 32'(eov));
    @(posedge clk); #1;
    chk({tag, " done_1cyc"}, 32'(divide_done), 32'd0);
    chk({tag, " busy_low"},  32'(busy), 32'd0);
    chk({tag, " q_stable"},  32'(quotient), 32'(eq));
  endtask

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    #12;
    chk("rst quotient",  32'(quotient), 32'd0);
    chk("rst remainder", 32'(remainder), 32'd0);
    chk("rst flags",     32'({div_by_zero, overflow}), 32'd0);
    chk("rst busy_done", 32'({busy, divide_done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("7/2",   4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0, 4'b0000, 0);
    run_op("-7/2",  4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0, 4'b0011, 0);
    run_op("6/-3",  4'b0110, 4'b1101, 4'b1110, 4'b0000, 1'b0, 1'b0, 4'b1101, 0);
    run_op("3/5",   4'b0011, 4'b0101, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b1110, 0);
    run_op("-8/-1", 4'b1000, 4'b1111, 4'b0111, 4'b0000, 1'b0, 1'b1, 4'b0000, 0);
    run_op("5/0",   4'b0101, 4'b0000, 4'b0000, 4'b0101, 1'b1, 1'b0, 4'b0111, 0);
    run_op("inj",   4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0, 4'b0000, 3);

    // Abort an operation in the middle of the iteration phase.
    @(posedge clk); #1;
    a = 4'b0111; b = 4'b0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst quotient",  32'(quotient), 32'd0);
    chk("mid_rst remainder", 32'(remainder), 32'd0);
    chk("mid_rst flags",     32'({div_by_zero, overflow}), 32'd0);
    chk("mid_rst busy_done", 32'({busy, divide_done}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (divide_done || busy) seen = 1'b1;
    end
    chk("mid_rst no_done", 32'(seen), 32'd0);

    run_op("4/2", 4'b0100, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
